instruction_fetch_unit: RTL and testbench

//  Initiator side of the instruction-memory read interface. Owns the PC and drives imem_addr.

---
 rtl/instruction_fetch_unit_if.sv | 24 ++
 rtl/instruction_fetch_unit.sv | 130 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory read port and IF/ID decode handshake of the fetch unit.
// The master modport is the fetch unit side; the slave modport is the memory/decode side.
interface instruction_fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        addr_fault;

  modport master (
    output imem_addr, id_valid, id_instr, id_pc, id_pc_plus4, addr_fault,
    input  imem_rd, id_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_addr, id_valid, id_instr, id_pc, id_pc_plus4, addr_fault,
    output imem_rd, id_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, captures imem_rd into the IF/ID register, handles redirects and fetch faults.
// Optional IF_PERF_CNT_EN adds perf_fetch_cnt / perf_stall_cnt outputs.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 1024,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                      clk,
  input  logic                      reset,
  instruction_fetch_unit_if.master  bus
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]               perf_fetch_cnt,
  output logic [31:0]               perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  localparam logic [29:0] DEPTH_W = 30'(IMEM_DEPTH);

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] instr_p1, instr_nxt;
  logic [31:0] pc_p1, pc_p1_nxt;
  logic [31:0] pc4_p1, pc4_nxt;
  logic        vld_p1, vld_nxt;
  logic        fault, fault_nxt;
  logic        advance;
  logic        capture;
  logic        redirect_ok;

  function automatic logic legal_addr(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a[31:2] < DEPTH_W);
  endfunction

  assign advance     = !vld_p1 || bus.id_ready;
  assign redirect_ok = legal_addr(bus.redirect_pc);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = instr_p1;
    pc_p1_nxt = pc_p1;
    pc4_nxt   = pc4_p1;
    vld_nxt   = vld_p1;
    fault_nxt = fault;
    capture   = 1'b0;
    case (state)
      BOOT: begin
        state_nxt = RUN;
        if (bus.redirect && redirect_ok) pc_nxt = bus.redirect_pc;
      end
      RUN: begin
        if (bus.redirect) begin
          pc_nxt  = bus.redirect_pc;
          vld_nxt = 1'b0;
          if (redirect_ok) begin
            instr_nxt = NOP_INSTR;
          end else begin
            fault_nxt = 1'b1;
            state_nxt = HALT;
          end
        end else if (advance && !legal_addr(pc)) begin
          // pc is always word aligned here, so this is purely the range check
          vld_nxt   = 1'b0;
          fault_nxt = 1'b1;
          state_nxt = HALT;
        end else if (advance) begin
          capture   = 1'b1;
          instr_nxt = bus.imem_rd;
          pc_p1_nxt = pc;
          pc4_nxt   = pc + 32'd4;
          vld_nxt   = 1'b1;
          pc_nxt    = pc + 32'd4;
        end
      end
      HALT: begin
        vld_nxt = 1'b0;
        if (bus.redirect && redirect_ok) begin
          pc_nxt    = bus.redirect_pc;
          fault_nxt = 1'b0;
          state_nxt = RUN;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  // IF/ID stage boundary
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      instr_p1 <= NOP_INSTR;
      pc_p1    <= 32'd0;
      pc4_p1   <= 32'd0;
      vld_p1   <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      instr_p1 <= instr_nxt;
      pc_p1    <= pc_p1_nxt;
      pc4_p1   <= pc4_nxt;
      vld_p1   <= vld_nxt;
      fault    <= fault_nxt;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetch_cnt <= 32'd0;
      perf_stall_cnt <= 32'd0;
    end else begin
      if (capture) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (state == RUN && vld_p1 && !bus.id_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

  assign bus.imem_addr   = pc;
  assign bus.id_valid    = vld_p1;
  assign bus.id_instr    = instr_p1;
  assign bus.id_pc       = pc_p1;
  assign bus.id_pc_plus4 = pc4_p1;
  assign bus.addr_fault  = fault;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed testbench for instruction_fetch_unit with a combinational instruction memory model.
module tb_instruction_fetch_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [31:0] mem [0:1023];

  instruction_fetch_unit_if ifc ();

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
  instruction_fetch_unit dut (.clk(clk), .reset(reset), .bus(ifc),
                              .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt));
`else
  instruction_fetch_unit dut (.clk(clk), .reset(reset), .bus(ifc));
`endif

  always #5 clk = ~clk;

  assign ifc.imem_rd = (!reset || ifc.imem_addr[31:12] != 20'd0) ? 32'd0 : mem[ifc.imem_addr[11:2]];

  task automatic do_reset_boot();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (ifc.id_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%h want=0", ifc.id_valid); end
    total++; if (ifc.id_instr !== 32'h13) begin bad++; $display("FAIL rst_instr got=%h want=00000013", ifc.id_instr); end
    total++; if (ifc.id_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h want=0", ifc.id_pc); end
    total++; if (ifc.id_pc_plus4 !== 32'h0) begin bad++; $display("FAIL rst_pc4 got=%h want=0", ifc.id_pc_plus4); end
    total++; if (ifc.addr_fault !== 1'b0) begin bad++; $display("FAIL rst_fault got=%h want=0", ifc.addr_fault); end
    total++; if (ifc.imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h want=0", ifc.imem_addr); end
  endtask

  task automatic test_sequential_fetch();
    logic [31:0] exp_i [0:2];
    exp_i[0] = 32'h00A00093; exp_i[1] = 32'h03200113; exp_i[2] = 32'h01400193;
    ifc.id_ready = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    total++; if (ifc.id_valid !== 1'b0) begin bad++; $display("FAIL boot_valid got=%h want=0", ifc.id_valid); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (ifc.id_valid !== 1'b1) begin bad++; $display("FAIL seq_valid%0d got=%h want=1", k, ifc.id_valid); end
      total++; if (ifc.id_instr !== exp_i[k]) begin bad++; $display("FAIL seq_instr%0d got=%h want=%h", k, ifc.id_instr, exp_i[k]); end
      total++; if (ifc.id_pc !== 32'(4*k)) begin bad++; $display("FAIL seq_pc%0d got=%h want=%h", k, ifc.id_pc, 32'(4*k)); end
      total++; if (ifc.id_pc_plus4 !== 32'(4*k+4)) begin bad++; $display("FAIL seq_pc4%0d got=%h want=%h", k, ifc.id_pc_plus4, 32'(4*k+4)); end
    end
  endtask

  task automatic test_stall();
    do_reset_boot();
    ifc.id_ready = 1'b1;
    @(negedge clk);
    ifc.id_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (ifc.id_instr !== 32'h00A00093) begin bad++; $display("FAIL stall_instr%0d got=%h want=00a00093", k, ifc.id_instr); end
      total++; if (ifc.id_pc !== 32'h0) begin bad++; $display("FAIL stall_pc%0d got=%h want=0", k, ifc.id_pc); end
      total++; if (ifc.imem_addr !== 32'h4) begin bad++; $display("FAIL stall_addr%0d got=%h want=4", k, ifc.imem_addr); end
      total++; if (ifc.id_valid !== 1'b1) begin bad++; $display("FAIL stall_valid%0d got=%h want=1", k, ifc.id_valid); end
    end
    ifc.id_ready = 1'b1;
    @(negedge clk);
    total++; if (ifc.id_instr !== 32'h03200113) begin bad++; $display("FAIL unstall_instr got=%h want=03200113", ifc.id_instr); end
    total++; if (ifc.id_pc !== 32'h4) begin bad++; $display("FAIL unstall_pc got=%h want=4", ifc.id_pc); end
  endtask

  task automatic test_redirect_flush();
    ifc.id_ready = 1'b0;
    ifc.redirect = 1'b1;
    ifc.redirect_pc = 32'h14;
    @(negedge clk);
    ifc.redirect = 1'b0;
    ifc.id_ready = 1'b1;
    total++; if (ifc.id_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%h want=0", ifc.id_valid); end
    total++; if (ifc.id_instr !== 32'h13) begin bad++; $display("FAIL flush_instr got=%h want=00000013", ifc.id_instr); end
    total++; if (ifc.imem_addr !== 32'h14) begin bad++; $display("FAIL flush_addr got=%h want=14", ifc.imem_addr); end
    @(negedge clk);
    total++; if (ifc.id_pc !== 32'h14) begin bad++; $display("FAIL redir_pc got=%h want=14", ifc.id_pc); end
    total++; if (ifc.id_instr !== 32'h00208333) begin bad++; $display("FAIL redir_instr got=%h want=00208333", ifc.id_instr); end
    total++; if (ifc.id_pc_plus4 !== 32'h18) begin bad++; $display("FAIL redir_pc4 got=%h want=18", ifc.id_pc_plus4); end
  endtask

  task automatic test_illegal_redirect();
    ifc.redirect = 1'b1;
    ifc.redirect_pc = 32'h6;
    @(negedge clk);
    ifc.redirect = 1'b0;
    total++; if (ifc.addr_fault !== 1'b1) begin bad++; $display("FAIL mis_fault got=%h want=1", ifc.addr_fault); end
    total++; if (ifc.id_valid !== 1'b0) begin bad++; $display("FAIL mis_valid got=%h want=0", ifc.id_valid); end
    total++; if (ifc.imem_addr !== 32'h6) begin bad++; $display("FAIL mis_addr got=%h want=6", ifc.imem_addr); end
    repeat (2) @(negedge clk);
    total++; if (ifc.id_valid !== 1'b0) begin bad++; $display("FAIL halt_valid got=%h want=0", ifc.id_valid); end
    total++; if (ifc.addr_fault !== 1'b1) begin bad++; $display("FAIL halt_fault got=%h want=1", ifc.addr_fault); end
    ifc.redirect = 1'b1;
    ifc.redirect_pc = 32'h18;
    @(negedge clk);
    ifc.redirect = 1'b0;
    total++; if (ifc.addr_fault !== 1'b0) begin bad++; $display("FAIL recov_fault got=%h want=0", ifc.addr_fault); end
    total++; if (ifc.id_valid !== 1'b0) begin bad++; $display("FAIL recov_valid got=%h want=0", ifc.id_valid); end
    @(negedge clk);
    total++; if (ifc.id_instr !== 32'h401103B3) begin bad++; $display("FAIL recov_instr got=%h want=401103b3", ifc.id_instr); end
    total++; if (ifc.id_pc !== 32'h18) begin bad++; $display("FAIL recov_pc got=%h want=18", ifc.id_pc); end
  endtask

  task automatic test_range_end();
    ifc.id_ready = 1'b1;
    ifc.redirect = 1'b1;
    ifc.redirect_pc = 32'hFF8;
    @(negedge clk);
    ifc.redirect = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (ifc.id_instr !== 32'hCAFE0FFC) begin bad++; $display("FAIL end_instr got=%h want=cafe0ffc", ifc.id_instr); end
    total++; if (ifc.id_pc !== 32'hFFC) begin bad++; $display("FAIL end_pc got=%h want=ffc", ifc.id_pc); end
    total++; if (ifc.id_pc_plus4 !== 32'h1000) begin bad++; $display("FAIL end_pc4 got=%h want=1000", ifc.id_pc_plus4); end
    total++; if (ifc.imem_addr !== 32'h1000) begin bad++; $display("FAIL end_addr got=%h want=1000", ifc.imem_addr); end
    @(negedge clk);
    total++; if (ifc.addr_fault !== 1'b1) begin bad++; $display("FAIL oor_fault got=%h want=1", ifc.addr_fault); end
    total++; if (ifc.id_valid !== 1'b0) begin bad++; $display("FAIL oor_valid got=%h want=0", ifc.id_valid); end
    repeat (2) @(negedge clk);
    total++; if (ifc.id_valid !== 1'b0) begin bad++; $display("FAIL oor_hold_valid got=%h want=0", ifc.id_valid); end
    total++; if (ifc.id_pc !== 32'hFFC) begin bad++; $display("FAIL oor_hold_pc got=%h want=ffc", ifc.id_pc); end
    total++; if (ifc.imem_addr !== 32'h1000) begin bad++; $display("FAIL oor_hold_addr got=%h want=1000", ifc.imem_addr); end
  endtask

  task automatic test_async_reset();
    do_reset_boot();
    ifc.id_ready = 1'b1;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    total++; if (ifc.id_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%h want=0", ifc.id_valid); end
    total++; if (ifc.id_instr !== 32'h13) begin bad++; $display("FAIL arst_instr got=%h want=00000013", ifc.id_instr); end
    total++; if (ifc.id_pc !== 32'h0) begin bad++; $display("FAIL arst_pc got=%h want=0", ifc.id_pc); end
    total++; if (ifc.id_pc_plus4 !== 32'h0) begin bad++; $display("FAIL arst_pc4 got=%h want=0", ifc.id_pc_plus4); end
    total++; if (ifc.imem_addr !== 32'h0) begin bad++; $display("FAIL arst_addr got=%h want=0", ifc.imem_addr); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++; if (ifc.id_valid !== 1'b0) begin bad++; $display("FAIL reboot_valid got=%h want=0", ifc.id_valid); end
    @(negedge clk);
    total++; if (ifc.id_instr !== 32'h00A00093) begin bad++; $display("FAIL reboot_instr got=%h want=00a00093", ifc.id_instr); end
`ifdef IF_PERF_CNT_EN
    repeat (2) @(negedge clk);
    ifc.id_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (perf_fetch_cnt !== 32'd3) begin bad++; $display("FAIL perf_fetch got=%0d want=3", perf_fetch_cnt); end
    total++; if (perf_stall_cnt !== 32'd2) begin bad++; $display("FAIL perf_stall got=%0d want=2", perf_stall_cnt); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0] = 32'h00A00093; mem[1] = 32'h03200113; mem[2] = 32'h01400193;
    mem[5] = 32'h00208333; mem[6] = 32'h401103B3;
    mem[1022] = 32'hCAFE0FF8; mem[1023] = 32'hCAFE0FFC;
    ifc.id_ready = 1'b1;
    ifc.redirect = 1'b0;
    ifc.redirect_pc = 32'h0;
    test_reset();
    test_sequential_fetch();
    test_stall();
    test_redirect_flush();
    test_illegal_redirect();
    test_range_end();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
